ifetch_prefetch: RTL and testbench
==================================

Name: ifetch_prefetch

Overview:
- Instruction prefetch stage in front of the CPU decode stage.
- Acts as a Wishbone classic read-only master on the instruction port of the dual-port RAM.
- Fetches sequential 32-bit words into a small FIFO and presents them with their word address over a valid/ready handshake.
- On a branch or exception, a flush redirects fetching to a new address.

Parameters:
AWIDTH, 15, word-address width; matches the RAM port address width.
DEPTH, 4, FIFO entries; power of two, at least 2.
RESET_ADDR, 0, word address fetched first after reset.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
cyc_o  output  1  Wishbone cycle; always equal to stb_o
stb_o  output  1  Wishbone strobe, registered
adr_o  output  AWIDTH  Wishbone word address, registered
ack_i  input  1  Wishbone acknowledge
dat_i  input  32  Wishbone read data, valid when ack_i=1
ir_o  output  32  instruction at FIFO head
pc_o  output  AWIDTH  word address of ir_o
valid_o  output  1  FIFO non-empty
ready_i  input  1  decode consumes head when valid_o and ready_i are both 1
flush_i  input  1  redirect request, single-cycle pulse
flush_adr_i  input  AWIDTH  new fetch word address

Behaviour:
- Reset values: cyc_o=0, stb_o=0, adr_o=RESET_ADDR, valid_o=0, ir_o=0, pc_o=0. FIFO is empty, fetch address fadr=RESET_ADDR, FSM is in S_IDLE.
- FSM states:
  - S_IDLE: no bus cycle.
  - S_BUS: stb_o=1, waiting for ack_i.
  - S_DRAIN: stb_o=1, waiting for ack_i; the returned data is discarded.
- Credit rule: a request may issue only when count + (stb_o ? 1 : 0) < DEPTH. At most one request is outstanding.
- S_IDLE -> S_BUS:
  - Taken when credit is available, at any edge while not in reset.
  - adr_o<=fadr, stb_o<=1.
  - The first stb_o rises on the first edge after rst_i deasserts.
- S_BUS with ack_i=1 sampled:
  - Push {adr_o, dat_i}; fadr<=fadr+1 (mod 2^AWIDTH).
  - If credit still allows after the push, stay in S_BUS with adr_o<=fadr+1 and stb_o held at 1 (back-to-back).
  - Otherwise go to S_IDLE with stb_o<=0.
  - Against the one-wait-state RAM this sustains one word every 2 cycles.
- stb_o and adr_o stay stable until ack_i is sampled.
- Latency: valid_o=1 and ir_o/pc_o are updated after the same edge that samples ack_i.
- Pop: when valid_o=1 and ready_i=1, the head advances at the edge. A push and a pop in the same cycle leave count unchanged.
- Flush takes priority over both push and pop. At the edge where flush_i=1:
  - The FIFO clears, so valid_o=0 next cycle; fadr<=flush_adr_i.
  - In S_BUS without ack_i: go to S_DRAIN and keep stb_o/adr_o.
  - In S_BUS with ack_i: discard the data and issue flush_adr_i immediately (S_BUS, adr_o<=flush_adr_i).
  - In S_IDLE: issue flush_adr_i at this edge.
  - In S_DRAIN: update fadr and remain in S_DRAIN.
- S_DRAIN with ack_i=1 and no flush: discard the data; adr_o<=fadr, stay in S_BUS-equivalent issue (go to S_BUS).
- Address wrap: fadr and adr_o wrap from 2^AWIDTH-1 to 0 with no error.
- ack_i received in S_IDLE is ignored.
- rst_i asserted mid-transaction: all state returns to reset values immediately; there is no drain.

Optional Feature:
- Macro: IFETCH_STATS_EN.
- Defined:
  - Adds output stall_cnt_o [31:0], reset to 0.
  - Increments (saturating at 32'hFFFFFFFF) on every cycle with ready_i=1 and valid_o=0.
  - Also adds output flush_cnt_o [15:0], wrapping, which counts flush_i pulses.
- Not defined: neither port exists, and there is no related logic.

Decomposition:
- Package bexkat1_fetch_pkg: state enum (S_IDLE, S_BUS, S_DRAIN) and struct fetch_entry_t {adr[AWIDTH-1:0], ir[31:0]}.
  - Because the struct width depends on a parameter, the package defines it at the default width and the top level uses the parameter.
- Sub-module fetch_fifo:
  - Synchronous FIFO with parameters DEPTH and WIDTH.
  - Ports: push, pop, clear, count, head.
  - Asynchronous reset; clear has priority over push and pop.

Test Plan:
- Reset release with the RAM model (1-cycle ack) holding words 0..7 = 0x1000+i, ready_i=0:
  - stb_o rises on edge 1 with adr_o=0.
  - After 4 words, stb_o drops and count=4.
  - pc_o=0, ir_o=0x1000.
- Then ready_i=1 held: the sequence pc 0,1,2,... with ir 0x1000.. continues with no gaps or duplicates. Steady state gives valid_o at 50% duty.
- flush_i with flush_adr_i=0x40 while a request is outstanding without ack:
  - The old request is held until ack and then discarded (S_DRAIN).
  - The next adr_o is 0x40; the first pc_o after flush is 0x40.
- flush_i in the same cycle as ack_i and a pop: the acked data never appears, valid_o=0 next cycle, and adr_o=flush_adr_i on that edge.
- RESET_ADDR=0x7FFE with AWIDTH=15: fetch sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- rst_i pulsed while stb_o=1: outputs return to reset values, and fetching restarts at RESET_ADDR. With IFETCH_STATS_EN, stall_cnt_o counts exactly the empty-cycles with ready_i=1.

Source files
------------

// File: rtl/ifetch_prefetch_pkg.sv
// Shared types for the instruction prefetch stage.
// Provides the fetch FSM state encoding and the FIFO entry layout
// (word address + instruction) at the default address width; the top
// level rebuilds the entry at its own AWIDTH.
package bexkat1_fetch_pkg;

    localparam int unsigned FETCH_AWIDTH = 15;
    localparam int unsigned IR_W         = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_AWIDTH-1:0] adr;
        logic [IR_W-1:0]         ir;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Wishbone classic read-only instruction bus.
// Members: cyc_o/stb_o/adr_o driven by the fetch master,
//          ack_i/dat_i driven by the RAM instruction port.
// Modports: master (prefetch stage), slave (memory).
interface ifetch_prefetch_if #(
    parameter int unsigned AWIDTH = 15
);
    logic              cyc_o;
    logic              stb_o;
    logic [AWIDTH-1:0] adr_o;
    logic              ack_i;
    logic [31:0]       dat_i;

    modport master (output cyc_o, output stb_o, output adr_o,
                    input  ack_i, input  dat_i);
    modport slave  (input  cyc_o, input  stb_o, input  adr_o,
                    output ack_i, output dat_i);
endinterface

// File: rtl/ifetch_prefetch_fifo.sv
// Small synchronous FIFO holding fetched {address, instruction} entries.
// Ports: clk_i, rst_i (async, active-high), push/din write, pop advances
//        head, clear empties the FIFO and wins over push and pop,
//        count = occupancy, head = oldest entry, valid = registered non-empty.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 47
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head,
    output logic                   valid
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;

    // Occupancy after this edge
    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else begin
            count_nxt = CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
        end
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= count_nxt;
            valid <= (count_nxt != '0);
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch stage: Wishbone classic read-only master that
// fetches sequential words into a FIFO and hands them to decode over a
// valid/ready handshake; flush redirects fetching to a new address.
// Ports: clk_i, rst_i (async, active-high); wb (ifetch_prefetch_if.master);
//        ir_o/pc_o/valid_o head of FIFO, ready_i consume;
//        flush_i/flush_adr_i redirect.
// Optional (macro IFETCH_STATS_EN): stall_cnt_o (saturating count of
//        cycles with ready_i=1 and valid_o=0), flush_cnt_o (wrapping
//        count of flush pulses).
module ifetch_prefetch
    import bexkat1_fetch_pkg::*;
#(
    parameter int unsigned     AWIDTH     = 15,
    parameter int unsigned     DEPTH      = 4,
    parameter logic [AWIDTH-1:0] RESET_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ifetch_prefetch_if.master wb,
    output logic [31:0]       ir_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic              flush_i,
    input  logic [AWIDTH-1:0] flush_adr_i
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [15:0]       flush_cnt_o
`endif
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AWIDTH-1:0] adr;
        logic [IR_W-1:0]   ir;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    fetch_state_t      state_q, state_d;
    logic              stb_q, stb_d;
    logic [AWIDTH-1:0] adr_q, adr_d;
    logic [AWIDTH-1:0] fadr_q, fadr_d;
    logic [AWIDTH-1:0] fadr_inc;

    logic              push;
    logic              pop;
    logic              clear;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after;
    logic              credit;
    entry_t            din_e;
    entry_t            head_e;

    // FIFO data path
    assign push  = (state_q == S_BUS) && wb.ack_i && !flush_i;
    assign pop   = valid_o && ready_i && !flush_i;
    assign clear = flush_i;

    assign din_e.adr = adr_q;
    assign din_e.ir  = wb.dat_i;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (din_e),
        .count (count),
        .head  (head_e),
        .valid (valid_o)
    );

    assign ir_o = head_e.ir;
    assign pc_o = head_e.adr;

    // A new request may issue only if its word will still fit once this
    // edge's push/pop/clear has settled.
    assign count_after = clear ? '0 : CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
    assign credit      = (count_after < CNT_W'(DEPTH));
    assign fadr_inc    = fadr_q + AWIDTH'(1);

    // Next-state and bus request logic
    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        adr_d   = adr_q;
        fadr_d  = fadr_q;
        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    fadr_d  = flush_adr_i;
                    adr_d   = flush_adr_i;
                    stb_d   = 1'b1;
                    state_d = S_BUS;
                end else if (credit) begin
                    adr_d   = fadr_q;
                    stb_d   = 1'b1;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (wb.ack_i) begin
                    if (flush_i) begin
                        fadr_d = flush_adr_i;
                        adr_d  = flush_adr_i;
                    end else begin
                        fadr_d = fadr_inc;
                        if (credit) begin
                            adr_d = fadr_inc;
                        end else begin
                            stb_d   = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end else if (flush_i) begin
                    // Keep the stale request on the bus until it completes
                    fadr_d  = flush_adr_i;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (wb.ack_i) begin
                    // Stale data dropped; a flush arriving with the ack
                    // redirects straight away since nothing is left to drain
                    state_d = S_BUS;
                    if (flush_i) begin
                        fadr_d = flush_adr_i;
                        adr_d  = flush_adr_i;
                    end else begin
                        adr_d = fadr_q;
                    end
                end else if (flush_i) begin
                    fadr_d = flush_adr_i;
                end
            end
            default: begin
                state_d = S_IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State and bus registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            stb_q   <= 1'b0;
            adr_q   <= RESET_ADDR;
            fadr_q  <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            fadr_q  <= fadr_d;
        end
    end

    assign wb.cyc_o = stb_q;
    assign wb.stb_o = stb_q;
    assign wb.adr_o = adr_q;

`ifdef IFETCH_STATS_EN
    // Decode-starvation and redirect counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (ready_i && !valid_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (flush_i) begin
                flush_cnt_o <= flush_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: two instances (RESET_ADDR 0 and
// 0x7FFE) each fed by a one-wait-state RAM model returning 0x1000+address.
module tb_ifetch_prefetch;

    logic        clk;
    logic        rst;
    logic        ready0, ready1;
    logic        flush0, flush1;
    logic [14:0] flush_adr0, flush_adr1;
    logic        ram_en0;
    logic [31:0] ir0, ir1;
    logic [14:0] pc0, pc1;
    logic        valid0, valid1;
`ifdef IFETCH_STATS_EN
    logic [31:0] stall0, stall1;
    logic [15:0] fcnt0, fcnt1;
`endif

    int checks = 0;
    int errors = 0;
    int exp_pc;
    int vcnt;

    ifetch_prefetch_if #(.AWIDTH(15)) bus0 ();
    ifetch_prefetch_if #(.AWIDTH(15)) bus1 ();

    ifetch_prefetch #(.AWIDTH(15), .DEPTH(4), .RESET_ADDR(15'h0000)) u0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .wb          (bus0),
        .ir_o        (ir0),
        .pc_o        (pc0),
        .valid_o     (valid0),
        .ready_i     (ready0),
        .flush_i     (flush0),
        .flush_adr_i (flush_adr0)
`ifdef IFETCH_STATS_EN
        ,
        .stall_cnt_o (stall0),
        .flush_cnt_o (fcnt0)
`endif
    );

    ifetch_prefetch #(.AWIDTH(15), .DEPTH(4), .RESET_ADDR(15'h7FFE)) u1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .wb          (bus1),
        .ir_o        (ir1),
        .pc_o        (pc1),
        .valid_o     (valid1),
        .ready_i     (ready1),
        .flush_i     (flush1),
        .flush_adr_i (flush_adr1)
`ifdef IFETCH_STATS_EN
        ,
        .stall_cnt_o (stall1),
        .flush_cnt_o (fcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-wait-state RAM models: word at address a holds 0x1000 + a
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus0.ack_i <= 1'b0;
            bus0.dat_i <= '0;
        end else begin
            bus0.ack_i <= bus0.stb_o && !bus0.ack_i && ram_en0;
            bus0.dat_i <= 32'h1000 + 32'(bus0.adr_o);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus1.ack_i <= 1'b0;
            bus1.dat_i <= '0;
        end else begin
            bus1.ack_i <= bus1.stb_o && !bus1.ack_i;
            bus1.dat_i <= 32'h1000 + 32'(bus1.adr_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        ready0     = 1'b0;
        ready1     = 1'b1;
        flush0     = 1'b0;
        flush1     = 1'b0;
        flush_adr0 = '0;
        flush_adr1 = '0;
        ram_en0    = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_stb",   32'(bus0.stb_o), 32'd0);
        check("rst_cyc",   32'(bus0.cyc_o), 32'd0);
        check("rst_adr",   32'(bus0.adr_o), 32'd0);
        check("rst_valid", 32'(valid0),     32'd0);
        check("rst_ir",    ir0,             32'd0);
        check("rst_pc",    32'(pc0),        32'd0);
        check("rst_adr1",  32'(bus1.adr_o), 32'h7FFE);

        // Fill with decode stalled
        rst = 1'b0;
        tick(); // edge 1
        check("e1_stb",  32'(bus0.stb_o), 32'd1);
        check("e1_cyc",  32'(bus0.cyc_o), 32'd1);
        check("e1_adr",  32'(bus0.adr_o), 32'd0);
        check("e1_adr1", 32'(bus1.adr_o), 32'h7FFE);
        tick(); // edge 2
        check("e2_valid", 32'(valid0), 32'd0);
        tick(); // edge 3
        check("e3_valid", 32'(valid0), 32'd1);
        check("e3_pc",    32'(pc0),    32'd0);
        check("e3_ir",    ir0,         32'h1000);
        check("e3_adr",   32'(bus0.adr_o), 32'd1);
        check("w0_pc",    32'(pc1),    32'h7FFE);
        check("w0_ir",    ir1,         32'h8FFE);
        tick(); // edge 4
        tick(); // edge 5
        check("w1_pc", 32'(pc1), 32'h7FFF);
        check("w1_ir", ir1,      32'h8FFF);
        tick(); // edge 6
        tick(); // edge 7
        check("w2_pc", 32'(pc1), 32'h0000);
        check("w2_ir", ir1,      32'h1000);
        tick(); // edge 8
        check("e8_stb", 32'(bus0.stb_o), 32'd1);
        tick(); // edge 9
        check("full_stb",   32'(bus0.stb_o), 32'd0);
        check("full_count", 32'(u0.u_fifo.count), 32'd4);
        check("full_pc",    32'(pc0), 32'd0);
        check("full_ir",    ir0,      32'h1000);
        check("w3_pc",      32'(pc1), 32'h0001);
        check("w3_ir",      ir1,      32'h1001);

        // Drain with decode always ready: strictly sequential stream
        ready0 = 1'b1;
        exp_pc = 0;
        for (int i = 0; i < 100; i++) begin
            if (exp_pc == 12) break;
            if (valid0) begin
                check("seq_pc", 32'(pc0), 32'(exp_pc));
                check("seq_ir", ir0, 32'h1000 + 32'(exp_pc));
                exp_pc++;
            end
            tick();
        end
        check("seq_done", 32'(exp_pc), 32'd12);

        // Steady state: one word per two cycles
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid0) begin
                check("duty_pc", 32'(pc0), 32'(exp_pc));
                vcnt++;
                exp_pc++;
            end
            tick();
        end
        check("duty", 32'(vcnt), 32'd10);

        // Asynchronous reset while a request is on the bus
        check("pre_rst_stb", 32'(bus0.stb_o), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_stb",   32'(bus0.stb_o), 32'd0);
        check("mid_rst_cyc",   32'(bus0.cyc_o), 32'd0);
        check("mid_rst_adr",   32'(bus0.adr_o), 32'd0);
        check("mid_rst_valid", 32'(valid0),     32'd0);
        check("mid_rst_ir",    ir0,             32'd0);
        check("mid_rst_pc",    32'(pc0),        32'd0);
        ready0  = 1'b0;
        ram_en0 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("restart_stb", 32'(bus0.stb_o), 32'd1);
        check("restart_adr", 32'(bus0.adr_o), 32'd0);
        tick();
        tick();
        check("hold_stb",   32'(bus0.stb_o), 32'd1);
        check("hold_adr",   32'(bus0.adr_o), 32'd0);
        check("hold_valid", 32'(valid0),     32'd0);

        // Flush with a request outstanding and no ack
        flush0     = 1'b1;
        flush_adr0 = 15'h0040;
        ram_en0    = 1'b1;
        tick(); // F
        flush0 = 1'b0;
        check("drain_stb",   32'(bus0.stb_o), 32'd1);
        check("drain_adr",   32'(bus0.adr_o), 32'd0);
        check("drain_valid", 32'(valid0),     32'd0);
        tick(); // F+1: stale ack dropped
        check("redir_adr",   32'(bus0.adr_o), 32'h40);
        check("redir_stb",   32'(bus0.stb_o), 32'd1);
        check("redir_valid", 32'(valid0),     32'd0);
        tick(); // F+2
        tick(); // F+3
        check("f1_valid", 32'(valid0), 32'd1);
        check("f1_pc",    32'(pc0),    32'h40);
        check("f1_ir",    ir0,         32'h1040);
        ready0 = 1'b1;
        tick(); // F+4
        check("f2_empty", 32'(valid0), 32'd0);
        tick(); // F+5
        check("f2_pc", 32'(pc0), 32'h41);
        check("f2_ir", ir0,      32'h1041);
        tick(); // F+6
        tick(); // F+7
        check("f3_pc", 32'(pc0), 32'h42);
`ifdef IFETCH_STATS_EN
        check("stall_a", stall0,     32'd2);
        check("fcnt_a",  32'(fcnt0), 32'd1);
`endif
        tick(); // F+8
        tick(); // F+9
        check("f4_pc", 32'(pc0), 32'h43);
        ready0 = 1'b0;
        tick(); // F+10

        // Flush coinciding with ack and pop
        check("coinc_ack",   32'(bus0.ack_i), 32'd1);
        check("coinc_valid", 32'(valid0),     32'd1);
        check("coinc_adr",   32'(bus0.adr_o), 32'h44);
        ready0     = 1'b1;
        flush0     = 1'b1;
        flush_adr0 = 15'h0123;
        tick(); // F+11
        flush0 = 1'b0;
        check("cf_valid", 32'(valid0),     32'd0);
        check("cf_adr",   32'(bus0.adr_o), 32'h123);
        check("cf_stb",   32'(bus0.stb_o), 32'd1);
        tick(); // F+12
        check("cf_valid2", 32'(valid0), 32'd0);
        tick(); // F+13
        check("cf_new_valid", 32'(valid0), 32'd1);
        check("cf_new_pc",    32'(pc0),    32'h123);
        check("cf_new_ir",    ir0,         32'h1123);
`ifdef IFETCH_STATS_EN
        check("stall_b", stall0,     32'd5);
        check("fcnt_b",  32'(fcnt0), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
